comm_rx: RTL and testbench

COMM_RX -- requirements
Module: comm_rx

---
 rtl/comm_rx_if.sv | 29 ++
 rtl/comm_rx.sv | 149 ++++++++++++++
 tb/tb_comm_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/comm_rx_if.sv
// comm_rx_if -- bundles the serial line, CPU consume strobe and receiver
// status outputs of comm_rx.
//   c_rx        serial line from the transmitter (idle high, asynchronous)
//   rd_i        one-cycle consume strobe from the CPU side
//   data_o      last received byte
//   valid_o     unread byte present in data_o
//   busy_o      frame reception in progress
//   frame_err_o sticky: last frame had a low stop bit
//   overrun_o   sticky: a byte was overwritten while valid_o was set
// Modports: slave = receiver, master = line driver / CPU side.
interface comm_rx_if;
  logic       c_rx;
  logic       rd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output c_rx, rd_i,
    input  data_o, valid_o, busy_o, frame_err_o, overrun_o
  );

  modport slave (
    input  c_rx, rd_i,
    output data_o, valid_o, busy_o, frame_err_o, overrun_o
  );
endinterface

// File: rtl/comm_rx.sv
// comm_rx -- 8N1 serial receiver with 16x oversampling.
// Ports:
//   sys_clk_i  system clock, rising edge
//   sys_rst_i  asynchronous active-high reset
//   bus        comm_rx_if.slave: c_rx, rd_i in; data_o, valid_o, busy_o,
//              frame_err_o, overrun_o out
// Parameter BAUD_DIV: system clocks per oversample tick (16 ticks per bit).
module comm_rx #(
  parameter int BAUD_DIV = 27
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  comm_rx_if.slave   bus
);

  localparam int             TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0]  TICK_MAX = TW'(BAUD_DIV - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic          rx_p0, rx_p1;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [2:0]    state, state_nxt;
  logic [3:0]    samp_cnt, samp_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          stop_good, stop_bad;
  logic [7:0]    data_q;
  logic          valid_q, busy_q, ferr_q, ovr_q;

  assign tick = (tick_cnt == TICK_MAX);

  // Stage p0/p1: two-flop synchronizer on the asynchronous line; only rx_p1
  // is used for decoding.

  // Frame decoder: the start bit is confirmed on its 8th tick (mid bit), and
  // every later bit is sampled 16 ticks after the previous sample point.
  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_p1) begin
          state_nxt = START;
          samp_nxt  = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_cnt == 4'd7) begin
            samp_nxt = 4'd0;
            bit_nxt  = 3'd0;
            // A line already back high at mid start bit was a glitch.
            state_nxt = rx_p1 ? IDLE : DATA;
          end else begin
            samp_nxt = samp_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          samp_nxt = samp_cnt + 4'd1;
          if (samp_cnt == 4'd15) begin
            shift_nxt = {rx_p1, shift_reg[7:1]};
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          samp_nxt = samp_cnt + 4'd1;
          if (samp_cnt == 4'd15) begin
            if (rx_p1) begin
              stop_good = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) reports once, then waits for idle.
        if (rx_p1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rx_p0     <= 1'b1;
      rx_p1     <= 1'b1;
      tick_cnt  <= '0;
      state     <= IDLE;
      samp_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_p0     <= bus.c_rx;
      rx_p1     <= rx_p0;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      state     <= state_nxt;
      busy_q    <= (state_nxt != IDLE);
      samp_cnt  <= samp_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;

      // Stage output: a read clears status; a completing frame on the same
      // edge takes priority over the read.
      if (bus.rd_i) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (stop_good) begin
        data_q  <= shift_reg;
        valid_q <= 1'b1;
        ferr_q  <= 1'b0;
        ovr_q   <= valid_q & ~bus.rd_i;
      end else if (stop_bad) begin
        ferr_q  <= 1'b1;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_comm_rx.sv
// tb_comm_rx -- directed bench for comm_rx with a byte scoreboard.
module tb_comm_rx;
  localparam int BIT = 432;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];
  logic rd_hit;

  comm_rx_if bus ();

  comm_rx #(.BAUD_DIV(27)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int low_hold);
    bus.c_rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.c_rx = b[i];
      clks(BIT);
    end
    bus.c_rx = stop;
    clks(BIT);
    if (!stop) clks(low_hold);
    else bus.c_rx = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, 0);
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, bus.data_o}, {24'd0, e});
    end
  endtask

  task automatic pulse_rd;
    bus.rd_i = 1'b1;
    clks(1);
    bus.rd_i = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag, input int bound);
    for (int i = 0; i < bound && bus.busy_o; i++) clks(1);
    check(tag, {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  {24'd0, bus.data_o},     32'h00);
    check({tag, "_valid"}, {31'd0, bus.valid_o},     32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy_o},      32'd0);
    check({tag, "_ferr"},  {31'd0, bus.frame_err_o}, 32'd0);
    check({tag, "_ovr"},   {31'd0, bus.overrun_o},   32'd0);
  endtask

  task automatic rd_on_completion;
    rd_hit = 1'b0;
    for (int i = 0; i < 6000 && !rd_hit; i++) begin
      @(negedge clk);
      if (dut.stop_good) begin
        bus.rd_i = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0;
        rd_hit = 1'b1;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(4);
  endtask

  initial begin
    bus.c_rx = 1'b1;
    bus.rd_i = 1'b0;

    // Reset state
    clks(3);
    check_reset_vals("reset");
    rst = 1'b0;
    clks(BIT);

    // Good frame 0xA5, then consume it
    good_frame(8'hA5);
    expect_byte("a5_data");
    check("a5_valid", {31'd0, bus.valid_o}, 32'd1);
    check("a5_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
    check("a5_ovr",   {31'd0, bus.overrun_o}, 32'd0);
    check("a5_busy",  {31'd0, bus.busy_o}, 32'd0);
    pulse_rd();
    check("a5_rd_clear", {31'd0, bus.valid_o}, 32'd0);

    // Short low glitch is rejected
    bus.c_rx = 1'b0;
    clks(50);
    check("glitch_busy_hi", {31'd0, bus.busy_o}, 32'd1);
    clks(50);
    bus.c_rx = 1'b1;
    wait_not_busy("glitch_busy_fall", BIT);
    check("glitch_valid", {31'd0, bus.valid_o}, 32'd0);
    check("glitch_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
    check("glitch_ovr",   {31'd0, bus.overrun_o}, 32'd0);

    // Bad stop bit followed by a long break, then a good frame
    do_reset();
    clks(BIT);
    send_frame(8'h3C, 1'b0, 1000);
    check("brk_ferr",  {31'd0, bus.frame_err_o}, 32'd1);
    check("brk_busy",  {31'd0, bus.busy_o}, 32'd1);
    check("brk_data",  {24'd0, bus.data_o}, 32'h00);
    check("brk_valid", {31'd0, bus.valid_o}, 32'd0);
    clks(1000);
    bus.c_rx = 1'b1;
    clks(BIT);
    check("brk_idle",   {31'd0, bus.busy_o}, 32'd0);
    check("brk_sticky", {31'd0, bus.frame_err_o}, 32'd1);
    check("brk_data2",  {24'd0, bus.data_o}, 32'h00);
    good_frame(8'h55);
    expect_byte("x55_data");
    check("x55_valid", {31'd0, bus.valid_o}, 32'd1);
    check("x55_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
    pulse_rd();

    // Overrun: two frames without a read
    clks(BIT);
    good_frame(8'h11);
    expect_byte("ov11_data");
    check("ov11_ovr", {31'd0, bus.overrun_o}, 32'd0);
    good_frame(8'h22);
    expect_byte("ov22_data");
    check("ov22_valid", {31'd0, bus.valid_o}, 32'd1);
    check("ov22_ovr",   {31'd0, bus.overrun_o}, 32'd1);
    pulse_rd();
    check("ov_rd_valid", {31'd0, bus.valid_o}, 32'd0);
    check("ov_rd_ovr",   {31'd0, bus.overrun_o}, 32'd0);

    // Read coincident with completion: new byte wins, no overrun
    clks(BIT);
    good_frame(8'h11);
    expect_byte("co11_data");
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, 0);
      rd_on_completion();
    join
    check("co_rd_hit",  {31'd0, rd_hit}, 32'd1);
    expect_byte("co22_data");
    check("co22_valid", {31'd0, bus.valid_o}, 32'd1);
    check("co22_ovr",   {31'd0, bus.overrun_o}, 32'd0);

    // Reset in the middle of data bit 4 aborts the frame
    clks(BIT);
    bus.c_rx = 1'b0;
    clks(5 * BIT + BIT / 2);
    check("mid_busy", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    bus.c_rx = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(BIT);
    check("post_rst_idle", {31'd0, bus.busy_o}, 32'd0);
    good_frame(8'h0F);
    expect_byte("x0f_data");
    check("x0f_valid", {31'd0, bus.valid_o}, 32'd1);
    check("x0f_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
    check("x0f_ovr",   {31'd0, bus.overrun_o}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
